fir_mac_engine: RTL and testbench
=================================

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 SHALL have parameter IN_W, 24, raw sample width.
REQ-002 SHALL have parameter DATA_W, 16, working sample width; the top DATA_W bits of in_sample are used.
REQ-003 SHALL have parameter COEF_W, 16, coefficient width.
REQ-004 SHALL have parameter NTAPS, 10, number of taps (2..256).
REQ-005 SHALL have parameter OUT_W, 16, output width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when high together with in_valid.
- in_sample  in  IN_W  signed raw sample.
- flush  in  1  zero the sample window.
- gain  in  5  right-shift amount.
- coef_addr  out  clog2(NTAPS)  tap index to the external coefficient store.
- coef_data  in  COEF_W  signed coefficient; valid one cycle after coef_addr.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  signed filtered sample.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-007 SHALL use states IDLE, MAC, LAST, OUT; in_ready = (state==IDLE) && !flush.
REQ-008 On accept, SHALL shift the window (win[0] <= in_sample[IN_W-1 -: DATA_W], win[k] <= win[k-1]), clear the accumulator, latch gain, and go to MAC with k=0.
REQ-009 In MAC cycle k, SHALL drive coef_addr=k; for k>=1, SHALL add coef_data*win[k-1] (signed x signed) to the accumulator; after k=NTAPS-1, SHALL go to LAST.
REQ-010 In LAST, SHALL add coef_data*win[NTAPS-1], register the scaled result into out_data, and go to OUT.
REQ-011 The accumulator SHALL be DATA_W+COEF_W+clog2(NTAPS) bits wide and SHALL never overflow.
REQ-012 Scaling: if latched gain>0, add 2^(gain-1); then shift right arithmetically by gain; then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-013 out_valid SHALL be high exactly in OUT; out_data SHALL be stable while out_valid && !out_ready; the handshake returns to IDLE.
REQ-014 Latency SHALL be NTAPS+2 cycles from the accept edge to the first cycle of out_valid; throughput is one sample per NTAPS+3 cycles with out_ready held high.
REQ-015 flush in IDLE SHALL zero all window entries on the next edge; flush outside IDLE SHALL be ignored; flush with in_valid in IDLE: flush wins and the sample is not accepted.
REQ-016 in_sample and gain SHALL be ignored outside the accept cycle.
REQ-017 coef_addr SHALL be 0 outside MAC.

Reset
REQ-018 Reset SHALL force, asynchronously: state=IDLE, window=0, accumulator=0, out_data=0, out_valid=0, busy=0, coef_addr=0, latched gain=0.
REQ-019 Reset asserted mid-MAC or in OUT SHALL abort the computation with no out_valid pulse; in_ready SHALL be high on the first cycle after deassertion.

Structure
REQ-020 Package fir_pkg SHALL hold the state enum, the default parameter constants, and an accumulator-width function.
REQ-021 Rounding/shift/saturation SHALL be a combinational sub-module fir_round_sat, parametrised by ACC_W and OUT_W.

Verification
REQ-022 Impulse: coef[k]=k+1, gain=0, one sample 24'h000100 followed by zeros -> out_data = 1,2,...,10, then 0.
REQ-023 Saturation: all coef=16'h7FFF, ten samples 24'h7FFF00, gain=0 -> out_data=16'h7FFF; with samples 24'h800000 and coef 16'h7FFF -> 16'h8000.
REQ-024 Rounding: coef[0]=3, others 0, gain=1; sample +1 -> 2; sample -1 -> -1.
REQ-025 Backpressure: out_ready low for 5 cycles -> out_valid and out_data held, in_ready low; one cycle after the handshake, in_ready is high.
REQ-026 Reset in MAC cycle k=4 -> no out_valid; the next sample after reset yields a result computed from a zeroed window; flush+in_valid in IDLE -> in_ready=0 and window cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine: FSM states,
// default parameter values and the accumulator sizing rule.
package fir_pkg;

   localparam int DEF_IN_W   = 24;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_COEF_W = 16;
   localparam int DEF_NTAPS  = 10;
   localparam int DEF_OUT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      LAST = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Each product is bounded by 2^(data_w+coef_w-2) in magnitude, so summing
   // ntaps of them needs clog2(ntaps) guard bits on top of the product width.
   function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
      return data_w + coef_w + $clog2(ntaps);
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output scaling: round-half-up, arithmetic right shift by
// gain, then clamp into the signed OUT_W range.
module fir_round_sat #(
   parameter int ACC_W = 36,
   parameter int OUT_W = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [4:0]              gain,
   output logic signed [OUT_W-1:0] result
);

   // One extra bit so adding the rounding constant can never wrap.
   localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W:0] acc_ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;

   // Round, shift and saturate in one combinational pass.
   always_comb begin
      acc_ext = {acc[ACC_W-1], acc};
      rnd     = '0;
      if (gain != 5'd0) begin
         rnd = (ACC_W+1)'(1) << (gain - 5'd1);
      end
      sum     = acc_ext + rnd;
      shifted = sum >>> gain;
      if (shifted > MAX_V) begin
         result = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         result = MIN_V[OUT_W-1:0];
      end else begin
         result = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential single-multiplier FIR filter. Each accepted sample shifts the
// window, then one tap is accumulated per cycle against an external
// coefficient store with one cycle of read latency.
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int NTAPS  = DEF_NTAPS,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_sample,
   input  logic                       flush,
   input  logic [4:0]                 gain,
   output logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]          coef_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic                       busy
);

   localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
   localparam int K_W    = $clog2(NTAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [K_W-1:0] K_LAST = K_W'(NTAPS - 1);

   state_t                    state_reg, state_next;
   logic [K_W-1:0]            k_reg;
   logic [K_W-1:0]            k_prev;
   logic signed [ACC_W-1:0]   acc_reg;
   logic [4:0]                gain_reg;
   logic signed [OUT_W-1:0]   out_data_reg;
   logic signed [DATA_W-1:0]  win_reg [NTAPS];

   logic                      accept;
   logic                      win_clear;
   logic signed [DATA_W-1:0]  win_sel;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [OUT_W-1:0]   scaled;

   // Flush takes priority over an offered sample in IDLE.
   assign in_ready  = (state_reg == IDLE) && !flush;
   assign accept    = in_ready && in_valid;
   assign win_clear = (state_reg == IDLE) && flush;
   assign out_data  = out_data_reg;

   // coef_data lags coef_addr by a cycle, so MAC cycle k pairs with tap k-1.
   assign k_prev = k_reg - 1'b1;

   // Select the window entry matching the coefficient arriving this cycle.
   always_comb begin
      win_sel = win_reg[NTAPS-1];
      if (state_reg == MAC) begin
         win_sel = win_reg[k_prev];
      end
   end

   assign prod    = $signed(coef_data) * win_sel;
   assign acc_sum = acc_reg + ACC_W'(prod);

   fir_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .acc    (acc_sum),
      .gain   (gain_reg),
      .result (scaled)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      out_valid  = (state_reg == OUT);
      coef_addr  = '0;
      case (state_reg)
         IDLE: if (accept) state_next = MAC;
         MAC: begin
            coef_addr = k_reg;
            if (k_reg == K_LAST) state_next = LAST;
         end
         LAST: state_next = OUT;
         OUT:  if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Tap counter, accumulator, latched gain and held output word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_reg        <= '0;
         acc_reg      <= '0;
         gain_reg     <= '0;
         out_data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  k_reg    <= '0;
                  acc_reg  <= '0;
                  gain_reg <= gain;
               end
            end
            MAC: begin
               if (k_reg != '0) acc_reg <= acc_sum;
               if (k_reg != K_LAST) k_reg <= k_reg + 1'b1;
               else                 k_reg <= '0;
            end
            LAST: out_data_reg <= scaled;
            default: ;
         endcase
      end
   end

   // Sample window: cleared by flush, shifted by one on each accepted sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) win_reg[i] <= '0;
      end else if (win_clear) begin
         for (int i = 0; i < NTAPS; i++) win_reg[i] <= '0;
      end else if (accept) begin
         for (int i = NTAPS-1; i > 0; i--) win_reg[i] <= win_reg[i-1];
         win_reg[0] <= in_sample[IN_W-1 -: DATA_W];
      end
   end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: a stimulus process queues the expected
// result of each accepted sample, a monitor checks each output handshake.
module tb_fir_mac_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_sample;
   logic        flush;
   logic [4:0]  gain;
   logic [3:0]  coef_addr;
   logic [15:0] coef_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   logic [15:0] coef_mem [10];
   logic [15:0] exp_q [$];
   string       name_q [$];

   int total = 0;
   int bad   = 0;

   fir_mac_engine dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sample (in_sample),
      .flush     (flush),
      .gain      (gain),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // External coefficient store with one cycle of read latency.
   always @(posedge clk) coef_data <= (coef_addr < 4'd10) ? coef_mem[coef_addr] : 16'h0000;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: every output handshake pops one expected result.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            automatic logic [15:0] e = exp_q.pop_front();
            automatic string nm = name_q.pop_front();
            $display("out  %s data=%h expected=%h", nm, out_data, e);
            chk(nm, {16'b0, out_data}, {16'b0, e});
         end
      end
   end

   task automatic send(input logic [23:0] s, input logic [4:0] g,
                       input logic [15:0] e, input string nm);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk({nm, "_in_ready_wait"}, {31'b0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_sample = s;
      gain      = g;
      exp_q.push_back(e);
      name_q.push_back(nm);
      $display("send %s sample=%h gain=%0d", nm, s, g);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_sample = 24'($urandom);
      gain      = 5'($urandom);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain"}, exp_q.size(), 32'd0);
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic coef_ramp();
      for (int i = 0; i < 10; i++) coef_mem[i] = 16'(i + 1);
   endtask

   task automatic coef_all(input logic [15:0] v);
      for (int i = 0; i < 10; i++) coef_mem[i] = v;
   endtask

   task automatic coef_first(input logic [15:0] v);
      for (int i = 0; i < 10; i++) coef_mem[i] = 16'h0000;
      coef_mem[0] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      reset     = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_sample = '0;
      gain      = '0;
      coef_ramp();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_coef_addr", {28'b0, coef_addr}, 32'd0);
      chk("rst_out_data",  {16'b0, out_data},  32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Impulse response of the ramp coefficients.
      send(24'h000100, 5'd0, 16'd1, "imp0");
      for (int i = 1; i < 10; i++) send(24'h000000, 5'd0, 16'(i + 1), $sformatf("imp%0d", i));
      send(24'h000000, 5'd0, 16'd0, "imp10");
      drain("imp");

      // Positive and negative saturation.
      coef_all(16'h7FFF);
      for (int i = 0; i < 10; i++) send(24'h7FFF00, 5'd0, 16'h7FFF, $sformatf("satp%0d", i));
      drain("satp");
      do_flush();
      for (int i = 0; i < 10; i++) send(24'h800000, 5'd0, 16'h8000, $sformatf("satn%0d", i));
      drain("satn");
      do_flush();

      // Rounding and shift by the latched gain.
      coef_first(16'd3);
      send(24'h000100, 5'd1, 16'h0002, "rnd_pos");
      send(24'hFFFF00, 5'd1, 16'hFFFF, "rnd_neg");
      send(24'h0001FF, 5'd1, 16'h0002, "rnd_lowbits");
      send(24'h006400, 5'd4, 16'h0013, "rnd_g4");
      send(24'hFFFB00, 5'd0, 16'hFFF1, "rnd_g0neg");
      drain("rnd");

      // Latency and backpressure.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(24'h000700, 5'd0, 16'h0015, "bp");
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 100);
      chk("latency", cyc, 32'd12);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_out_data",  {16'b0, out_data},  32'h0015);
         chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
      drain("bp");

      // Reset during MAC cycle k=4 aborts the computation.
      coef_ramp();
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 24'h000200;
      gain      = 5'd0;
      $display("send abort sample=%h gain=0", in_sample);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mac_coef_addr", {28'b0, coef_addr}, 32'd4);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_busy",      {31'b0, busy},      32'd0);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_coef_addr", {28'b0, coef_addr}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      send(24'h000100, 5'd0, 16'd1, "post_reset");
      drain("post_reset");

      // Flush with a simultaneous sample: flush wins, window cleared.
      send(24'h000300, 5'd0, 16'd5, "pre_flush");
      drain("pre_flush");
      @(negedge clk);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_sample = 24'h000900;
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_no_accept", {31'b0, busy}, 32'd0);
      send(24'h000100, 5'd0, 16'd1, "post_flush");
      drain("post_flush");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
